// File: rtl/detector_sched_pkg.sv
// Shared definitions for the detector scheduler: scheduler state codes and the
// "1110" Moore detector's pattern and state codes.
package detector_sched_pkg;

    localparam logic [2:0] SCHED_IDLE  = 3'd0;
    localparam logic [2:0] SCHED_CLEAR = 3'd1;
    localparam logic [2:0] SCHED_SHIFT = 3'd2;
    localparam logic [2:0] SCHED_DRAIN = 3'd3;
    localparam logic [2:0] SCHED_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = SCHED_IDLE,
        ST_CLEAR = SCHED_CLEAR,
        ST_SHIFT = SCHED_SHIFT,
        ST_DRAIN = SCHED_DRAIN,
        ST_DONE  = SCHED_DONE
    } sched_state_t;

    // Detector looks for serial 1,1,1,0 (MSB first), overlapping, Moore output.
    localparam logic [3:0] DET_PATTERN     = 4'b1110;
    localparam int         DET_PATTERN_LEN = 4;

    localparam logic [2:0] DET_S0    = 3'd0;
    localparam logic [2:0] DET_S1    = 3'd1;
    localparam logic [2:0] DET_S11   = 3'd2;
    localparam logic [2:0] DET_S111  = 3'd3;
    localparam logic [2:0] DET_S1110 = 3'd4;

endpackage

// File: rtl/detector_sched_arb.sv
// Two-requester round-robin arbiter; the pointer names the favoured requester
// and moves away from the winner only when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= gnt[0];
        end
    end

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] && (!req[1] || !ptr);
        gnt[1] = req[1] && (!req[0] ||  ptr);
    end

endmodule

// File: rtl/detector_sched.sv
// Arbitrates two word requesters, streams the granted word MSB-first into a
// shared pattern detector and returns the number of detections in that word.
module detector_sched
    import detector_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_x,
    output logic             det_clr,
    input  logic             det_detected,
    output logic             res_valid,
    output logic             res_tag,
    output logic [CNT_W-1:0] res_count,
    input  logic             res_ready,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sched_state_t     state, state_nxt;
    logic [WIDTH-1:0] word;
    logic             tag;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic [1:0]       gnt;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign accept = (state == ST_IDLE) && (req0_valid || req1_valid);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)      state_nxt = ST_CLEAR;
            ST_CLEAR:                  state_nxt = ST_SHIFT;
            ST_SHIFT: if (idx == '0)   state_nxt = ST_DRAIN;
            ST_DRAIN:                  state_nxt = ST_DONE;
            ST_DONE:  if (res_ready)   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // DRAIN exists so the flag produced by bit 0 is still counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word  <= '0;
            tag   <= 1'b0;
            idx   <= '0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        word <= gnt[1] ? req1_data : req0_data;
                        tag  <= gnt[1];
                    end
                end
                ST_CLEAR: begin
                    count <= '0;
                    idx   <= IDX_W'(WIDTH - 1);
                end
                ST_SHIFT: begin
                    if (idx != '0) idx <= idx - IDX_W'(1);
                    if (det_detected) count <= sat_inc(count);
                end
                ST_DRAIN: begin
                    if (det_detected) count <= sat_inc(count);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req0_ready = (state == ST_IDLE) && gnt[0];
        req1_ready = (state == ST_IDLE) && gnt[1];
        det_clr    = (state == ST_IDLE) || (state == ST_CLEAR);
        det_x      = (state == ST_SHIFT) ? word[idx] : 1'b0;
        busy       = (state != ST_IDLE);
        res_valid  = (state == ST_DONE);
        res_tag    = tag;
        res_count  = count;
    end

endmodule

// File: tb/tb_detector_sched.sv
// Scoreboard bench for detector_sched with a behavioural "1110" Moore detector.
module tb_detector_sched;
    import detector_sched_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
    logic             req0_ready, req1_ready;
    logic             det_x, det_clr, det_detected;
    logic             res_valid, res_tag, res_ready = 1'b1, busy;
    logic [CNT_W-1:0] res_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_edge = 0;
    int both_rdy = 0;
    logic busy_q = 1'b0, rv_q = 1'b0;
    logic [4:0] exp_q[$];
    logic [2:0] dstate;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    detector_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .det_x(det_x), .det_clr(det_clr), .det_detected(det_detected),
        .res_valid(res_valid), .res_tag(res_tag), .res_count(res_count),
        .res_ready(res_ready), .busy(busy)
    );

    // Shared detector: overlapping 1110, Moore flag, synchronous clear.
    always @(posedge clk or negedge rst) begin
        if (!rst) dstate <= DET_S0;
        else if (det_clr) dstate <= DET_S0;
        else begin
            case (dstate)
                DET_S0:   dstate <= det_x ? DET_S1 : DET_S0;
                DET_S1:   dstate <= det_x ? DET_S11 : DET_S0;
                DET_S11:  dstate <= det_x ? DET_S111 : DET_S0;
                DET_S111: dstate <= det_x ? DET_S111 : DET_S1110;
                default:  dstate <= det_x ? DET_S1 : DET_S0;
            endcase
        end
    end
    assign det_detected = (dstate == DET_S1110);

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (req0_ready && req1_ready) both_rdy++;
            if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) acc_edge = cyc + 1;
            if (busy && !busy_q) chk("clr_in_clear", int'(det_clr), 1);
            if (res_valid && !rv_q) chk("latency", cyc - acc_edge, WIDTH + 2);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: tag %0d count %0d with empty scoreboard",
                             res_tag, res_count);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    chk("res_tag", int'(res_tag), int'(e[4]));
                    chk("res_count", int'(res_count), int'(e[3:0]));
                end
            end
        end
        busy_q = busy;
        rv_q   = res_valid;
    end

    task automatic send(input int r, input logic [WIDTH-1:0] d, input int cnt, input bit push);
        bit ok = 0;
        if (push) exp_q.push_back({r[0], 4'(cnt)});
        if (r == 0) begin req0_valid = 1'b1; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_data = d; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("accept_in_time", int'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        chk("drain_in_time", int'(ok), 1);
    endtask

    initial begin
        int n0, n1;
        bit seen;
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_tag", int'(res_tag), 0);
        chk("rst_res_count", int'(res_count), 0);
        chk("rst_det_x", int'(det_x), 0);
        chk("rst_det_clr", int'(det_clr), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        send(0, 8'b11100000, 1, 1);
        wait_done();
        send(1, 8'b11101110, 2, 1);
        wait_done();

        // Both requesters contend for four words; expect 0,1,0,1.
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b1, 4'd2});
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b1, 4'd2});
        req0_valid = 1'b1; req0_data = 8'b11100000;
        req1_valid = 1'b1; req1_data = 8'b11101110;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 200 && (n0 < 2 || n1 < 2); i++) begin
            @(negedge clk);
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            @(posedge clk); #1;
            if (n0 == 2) req0_valid = 1'b0;
            if (n1 == 2) req1_valid = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_accepts", n0 + n1, 4);
        wait_done();

        send(0, 8'hFF, 0, 1);
        wait_done();
        send(0, 8'h00, 0, 1);
        wait_done();

        // Consumer stalls in DONE while requester 1 waits.
        res_ready = 1'b0;
        send(0, 8'b11100000, 1, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) begin seen = 1; break; end
        end
        chk("stall_res_valid_seen", int'(seen), 1);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(res_valid), 1);
            chk("stall_count", int'(res_count), 1);
            chk("stall_tag", int'(res_tag), 0);
            chk("stall_no_accept", int'(req1_ready), 0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        send(1, 8'h00, 0, 1);
        wait_done();

        // Reset while shifting bit 4 discards the word.
        send(0, 8'b11100000, 0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_res_valid", int'(res_valid), 0);
        chk("midrst_det_x", int'(det_x), 0);
        chk("midrst_det_clr", int'(det_clr), 1);
        @(posedge clk); #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("midrst_no_result", int'(seen), 0);
        @(posedge clk); #1;
        send(0, 8'b01110111, 1, 1);
        wait_done();

        chk("ready_exclusive", both_rdy, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
